stage_id_pipe: RTL and testbench
================================

STAGE_ID_PIPE -- requirements
Module: stage_id_pipe

Interface
REQ-001 Parameter DATA_W, default 32: width of register data, PC and sign-extended immediate; legal range 32..64.
REQ-002 Parameter REG_CNT, default 32: number of architectural registers; power of two, 8..32.
REQ-003 Parameter REG_AW, default $clog2(REG_CNT): register index width; instruction fields [25:21], [20:16] and [15:11] are truncated to REG_AW bits.
REQ-004 Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  in  1  IF stage presents an instruction.
REQ-007 in_pc  in  DATA_W  PC+4 of the presented instruction.
REQ-008 in_instr  in  32  instruction word.
REQ-009 id_ready  out  1  ID accepts the instruction this cycle (combinational).
REQ-010 ex_ready  in  1  EX accepts the ID/EX register contents this cycle.
REQ-011 flush  in  1  discard the instruction in ID and the ID/EX register.
REQ-012 wb_we  in  1; wb_addr  in  REG_AW; wb_data  in  DATA_W: register-file write port.
REQ-013 out_valid  out  1; out_pc  out  DATA_W; out_rs_data, out_rt_data  out  DATA_W; out_imm  out  DATA_W; out_rs, out_rt, out_rd  out  REG_AW: ID/EX register.
REQ-014 out_reg_dst, out_alu_src, out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write, out_illegal  out  1 each; out_alu_op  out  6: registered control.

Function
REQ-015 Register file SHALL hold REG_CNT x DATA_W words; register 0 SHALL read 0 and ignore writes.
REQ-016 A write SHALL occur on the rising edge when wb_we=1 and wb_addr!=0.
REQ-017 Decode: opcode 0 (R-type): reg_dst=1, reg_write=1, alu_op=funct[5:0]; 8 (addi): alu_src=1, reg_write=1; 35 (lw): alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1; 43 (sw): alu_src=1, mem_write=1; 4 (beq): branch=1. For all non-R opcodes alu_op=opcode.
REQ-018 Any other opcode SHALL produce all-zero control bits, alu_op=0 and illegal=1.
REQ-019 out_imm SHALL be in_instr[15:0] sign-extended to DATA_W.
REQ-020 Load-use hazard: hz=1 when out_valid=1, out_mem_read=1, out_rt!=0, and out_rt equals the decoded rs or rt of a valid incoming instruction.
REQ-021 id_ready SHALL equal ex_ready AND NOT hz.
REQ-022 On an edge with ex_ready=1 and hz=0: ID/EX loads the decoded instruction, and out_valid takes in_valid.
REQ-023 On an edge with ex_ready=1 and hz=1: out_valid<=0 (bubble); the other ID/EX fields SHALL be don't-care, and the control bits SHALL be 0.
REQ-024 On an edge with ex_ready=0: the ID/EX register SHALL hold all values.
REQ-025 flush=1 SHALL override REQ-022..024: out_valid<=0 and all control bits <=0; id_ready SHALL be 1 so IF discards the instruction.
REQ-026 Latency: the instruction is accepted on edge N and its decoded values are visible on the outputs after edge N.

Reset
REQ-027 While Reset=0: out_valid, all control bits, out_illegal, out_alu_op, out_pc, out_imm, out_rs_data, out_rt_data, out_rs, out_rt and out_rd SHALL be 0.
REQ-028 While Reset=0, all REG_CNT registers SHALL be 0.
REQ-029 Reset asserted mid-stall or mid-flush SHALL override all pending operations; operation resumes on the first edge after deassertion.

Configuration
REQ-030 Macro STAGE_ID_BYPASS_EN defined: a read of a register being written in the same cycle (wb_we=1, wb_addr=read index, nonzero) SHALL return wb_data.
REQ-031 Macro STAGE_ID_BYPASS_EN undefined: a read of a register being written in the same cycle SHALL return the pre-write array contents.

Verification
REQ-032 Write r5=0x1234 with wb_we=1; next cycle issue "add r3,r5,r0" -> out_rs_data=0x1234, out_reg_dst=1, out_reg_write=1, out_alu_op=0x20.
REQ-033 With r7=0x55 stored, write r7=0xAA and read r7 in the same cycle -> out_rs_data=0xAA with STAGE_ID_BYPASS_EN, 0x55 without.
REQ-034 Issue "lw r4,8(r1)" then "add r2,r4,r4" -> id_ready=0 for 1 cycle, one bubble with out_valid=0, then add presented with out_rs=4.
REQ-035 Hold ex_ready=0 for 3 cycles with sw in ID/EX -> outputs stable and id_ready=0; flush=1 -> out_valid=0 next cycle.
REQ-036 Issue opcode 0x3F with imm 0x8000 -> out_illegal=1, all control bits 0, out_imm=0xFFFF8000; Reset=0 asynchronously mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/stage_id_pipe.sv
// stage_id_pipe -- instruction decode stage with register file and ID/EX register.
//
// Purpose:
//   Decodes the instruction presented by IF, reads two source registers,
//   sign-extends the immediate and registers everything into the ID/EX
//   register. Detects the load-use hazard against the instruction already
//   in ID/EX and inserts a single bubble when needed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_pc/in_instr  instruction from IF (in_pc is PC+4)
//   id_ready              ID accepts the presented instruction this cycle
//   ex_ready              EX accepts the ID/EX contents this cycle
//   flush                 discard the instruction in ID and the ID/EX register
//   wb_we/wb_addr/wb_data register-file write port
//   out_*                 ID/EX register: data fields and decoded control
//
// Configuration:
//   STAGE_ID_BYPASS_EN    when defined, a read of the register being written
//                         in the same cycle returns wb_data; otherwise it
//                         returns the pre-write contents.
//
// Handshake: an instruction moves IF->ID/EX on a rising edge where
// in_valid=1 and id_ready=1. ID/EX contents move to EX on an edge where
// out_valid=1 and ex_ready=1; with ex_ready=0 every ID/EX field holds.
module stage_id_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int REG_AW  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [31:0]       in_instr,
  output logic              id_ready,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_dst,
  output logic              out_alu_src,
  output logic              out_branch,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic              out_illegal,
  output logic [5:0]        out_alu_op
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic [5:0] alu_op;
  } ctrl_t;

  // Register file
  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  // ID/EX register
  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [REG_AW-1:0] rs_q,     rs_d;
  logic [REG_AW-1:0] rt_q,     rt_d;
  logic [REG_AW-1:0] rd_q,     rd_d;
  ctrl_t             ctrl_q,   ctrl_d;

  // Decode of the presented instruction
  logic [5:0]        opcode;
  logic [REG_AW-1:0] dec_rs, dec_rt, dec_rd;
  logic [DATA_W-1:0] dec_imm, dec_rs_data, dec_rt_data;
  ctrl_t             dec_ctrl;
  logic              hz;

  always_comb begin
    opcode   = in_instr[31:26];
    dec_rs   = in_instr[21 +: REG_AW];
    dec_rt   = in_instr[16 +: REG_AW];
    dec_rd   = in_instr[11 +: REG_AW];
    dec_imm  = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    dec_ctrl = '0;
    case (opcode)
      6'd0: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = in_instr[5:0];
      end
      6'd8: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = opcode;
      end
      6'd35: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_op     = opcode;
      end
      6'd43: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_op    = opcode;
      end
      6'd4: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = opcode;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  // Register reads; r0 is hard-wired to zero regardless of array contents.
  always_comb begin
    dec_rs_data = (dec_rs == '0) ? '0 : regs_q[dec_rs];
    dec_rt_data = (dec_rt == '0) ? '0 : regs_q[dec_rt];
`ifdef STAGE_ID_BYPASS_EN
    if (wb_we && (wb_addr != '0) && (wb_addr == dec_rs)) dec_rs_data = wb_data;
    if (wb_we && (wb_addr != '0) && (wb_addr == dec_rt)) dec_rt_data = wb_data;
`endif
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_addr != '0)) regs_d[wb_addr] = wb_data;
  end

  // Load-use hazard: the load in ID/EX has not produced its data yet.
  always_comb begin
    hz = valid_q && ctrl_q.mem_read && (rt_q != '0) && in_valid &&
         ((rt_q == dec_rs) || (rt_q == dec_rt));
    // During a flush IF must drop its instruction, so report ready.
    id_ready = flush || (ex_ready && !hz);
  end

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (ex_ready) begin
      if (hz) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d   = in_valid;
        pc_d      = in_pc;
        rs_data_d = dec_rs_data;
        rt_data_d = dec_rt_data;
        imm_d     = dec_imm;
        rs_d      = dec_rs;
        rt_d      = dec_rt;
        rd_d      = dec_rd;
        ctrl_d    = dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= regs_d[i];
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_rs_data    = rs_data_q;
  assign out_rt_data    = rt_data_q;
  assign out_imm        = imm_q;
  assign out_rs         = rs_q;
  assign out_rt         = rt_q;
  assign out_rd         = rd_q;
  assign out_reg_dst    = ctrl_q.reg_dst;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_branch     = ctrl_q.branch;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_illegal    = ctrl_q.illegal;
  assign out_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe -- directed bench for stage_id_pipe with a reference model.
module tb_stage_id_pipe;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          in_valid = 0, ex_ready = 0, flush = 0, wb_we = 0;
  logic [DW-1:0] in_pc = '0, wb_data = '0;
  logic [31:0]   in_instr = '0;
  logic [AW-1:0] wb_addr = '0;
  logic          id_ready, out_valid;
  logic [DW-1:0] out_pc, out_rs_data, out_rt_data, out_imm;
  logic [AW-1:0] out_rs, out_rt, out_rd;
  logic          out_reg_dst, out_alu_src, out_branch, out_mem_read;
  logic          out_mem_write, out_mem_to_reg, out_reg_write, out_illegal;
  logic [5:0]    out_alu_op;

  stage_id_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_reg_dst(out_reg_dst), .out_alu_src(out_alu_src), .out_branch(out_branch),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal), .out_alu_op(out_alu_op)
  );

  // ctl = {reg_dst, alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write, illegal, alu_op}
  logic [13:0] dut_ctl;
  assign dut_ctl = {out_reg_dst, out_alu_src, out_branch, out_mem_read, out_mem_write,
                    out_mem_to_reg, out_reg_write, out_illegal, out_alu_op};

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] pc, rsd, rtd, imm;
    logic [AW-1:0] rs, rt, rd;
    logic [13:0]   ctl;
  } slot_t;

  slot_t         m;
  logic [DW-1:0] m_regs [32];

  // Control truth table straight from the opcode list.
  function automatic logic [13:0] ctl_of(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    case (op)
      6'd0:    return {8'b1000_0010, ins[5:0]};
      6'd8:    return {8'b0100_0010, 6'd8};
      6'd35:   return {8'b0101_0110, 6'd35};
      6'd43:   return {8'b0100_1000, 6'd43};
      6'd4:    return {8'b0010_0000, 6'd4};
      default: return {8'b0000_0001, 6'd0};
    endcase
  endfunction

  function automatic logic [DW-1:0] rd_reg(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = m_regs[a];
`ifdef STAGE_ID_BYPASS_EN
    if (wb_we && wb_addr != 0 && wb_addr == a) r = wb_data;
`endif
    return r;
  endfunction

  function automatic logic model_hz();
    return m.v && m.ctl[10] && m.rt != 0 && in_valid &&
           (m.rt == in_instr[25:21] || m.rt == in_instr[20:16]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.v = 0; m.pc = 0; m.rsd = 0; m.rtd = 0; m.imm = 0;
      m.rs = 0; m.rt = 0; m.rd = 0; m.ctl = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (flush || (ex_ready && model_hz())) begin
        m.v = 0;
        m.ctl = 0;
      end else if (ex_ready) begin
        m.v   = in_valid;
        m.pc  = in_pc;
        m.rs  = in_instr[25:21];
        m.rt  = in_instr[20:16];
        m.rd  = in_instr[15:11];
        m.rsd = rd_reg(m.rs);
        m.rtd = rd_reg(m.rt);
        m.imm = DW'($signed(in_instr[15:0]));
        m.ctl = ctl_of(in_instr);
      end
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
  end

  // ---------------- compare process (falling edge) ----------------
  always @(negedge clk) begin
    check("out_valid", out_valid, m.v);
    check("ctl", dut_ctl, m.ctl);
    check("id_ready", id_ready, flush || (ex_ready && !model_hz()));
    if (m.v || !rst_n) begin
      check("out_pc", out_pc, m.pc);
      check("out_rs_data", out_rs_data, m.rsd);
      check("out_rt_data", out_rt_data, m.rtd);
      check("out_imm", out_imm, m.imm);
      check("out_rs", out_rs, m.rs);
      check("out_rt", out_rt, m.rt);
      check("out_rd", out_rd, m.rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [DW-1:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic wb(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  // Directed table: instruction, write-back, ex_ready
  logic [31:0]   t_ins [6] = '{32'h20A9FFFF, 32'h10600010, 32'h00E54022,
                               32'h00001820, 32'h8C240008, 32'h00A01820};
  logic [AW-1:0] t_wa  [6] = '{5'd0, 5'd9, 5'd8, 5'd3, 5'd1, 5'd0};
  logic [DW-1:0] t_wd  [6] = '{32'hDEAD, 32'h99, 32'h88, 32'h33, 32'h11, 32'hBEEF};
  logic          t_er  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  // ---------------- stimulus ----------------
  initial begin
    step(); step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    ex_ready = 1'b1;

    // Write r5 then read it in add r3,r5,r0
    wb(1, 5'd5, 32'h1234); in_valid = 0;
    step();
    wb(0, 0, 0); issue(32'h00A01820, 32'h104);
    step();
    check("add_rs_data", out_rs_data, 32'h1234);
    check("add_reg_dst", out_reg_dst, 1'b1);
    check("add_reg_write", out_reg_write, 1'b1);
    check("add_alu_op", out_alu_op, 6'h20);

    // Same-cycle write/read of r7
    wb(1, 5'd7, 32'h55); in_valid = 0;
    step();
    wb(1, 5'd7, 32'hAA); issue(32'h00E00820, 32'h108);
    step();
    wb(0, 0, 0);
`ifdef STAGE_ID_BYPASS_EN
    check("bypass_rs_data", out_rs_data, 32'hAA);
`else
    check("nobypass_rs_data", out_rs_data, 32'h55);
`endif

    // Load-use: lw r4,8(r1) then add r2,r4,r4
    issue(32'h8C240008, 32'h200);
    step();
    issue(32'h00841020, 32'h204);
    #1;
    check("lu_id_ready_low", id_ready, 1'b0);
    step();
    check("lu_bubble", out_valid, 1'b0);
    check("lu_id_ready_back", id_ready, 1'b1);
    step();
    check("lu_add_valid", out_valid, 1'b1);
    check("lu_add_rs", out_rs, 5'd4);

    // Stall with sw r6,4(r2) in ID/EX, then flush
    issue(32'hAC460004, 32'h300);
    step();
    issue(32'h00A01820, 32'h304);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", out_valid, 1'b1);
      check("stall_mem_write", out_mem_write, 1'b1);
      check("stall_pc", out_pc, 32'h300);
      check("stall_id_ready", id_ready, 1'b0);
    end
    flush = 1'b1;
    #1;
    check("flush_id_ready", id_ready, 1'b1);
    step();
    check("flush_valid", out_valid, 1'b0);
    check("flush_mem_write", out_mem_write, 1'b0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Mixed table: r0 write ignored, stall cycle, bubbles with in_valid=0
    for (int i = 0; i < 6; i++) begin
      issue(t_ins[i], 32'h400 + 32'(i * 4));
      in_valid = (i != 3);
      wb(1, t_wa[i], t_wd[i]);
      ex_ready = t_er[i];
      step();
    end
    wb(0, 0, 0);
    ex_ready = 1'b1;
    issue(32'h00000020, 32'h500);  // add r0,r0,r0 reads r0 after r0 writes
    step();
    check("r0_reads_zero", out_rs_data, 32'h0);

    // Illegal opcode with negative immediate
    issue(32'hFC008000, 32'h600);
    step();
    check("ill_illegal", out_illegal, 1'b1);
    check("ill_ctl_zero", dut_ctl[13:7], 7'h0);
    check("ill_alu_op", out_alu_op, 6'h0);
    check("ill_imm", out_imm, 32'hFFFF8000);

    // Asynchronous reset while stalled
    ex_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_imm", out_imm, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_ctl", dut_ctl, 14'h0);
    step();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    issue(32'h00A00820, 32'h700);  // add r1,r5,r0: r5 cleared by reset
    step();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_rs_data", out_rs_data, 32'h0);
    in_valid = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
